// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode/funct constants and ALU operation codes for the ALU sequencer.
package alu_op_sequencer_pkg;

  // Instruction opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_MULI  = 6'h1D;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h2C;

  // ALU operation codes
  localparam logic [5:0] OPRN_NONE = 6'h00;
  localparam logic [5:0] OPRN_ADD  = 6'h01;
  localparam logic [5:0] OPRN_SUB  = 6'h02;
  localparam logic [5:0] OPRN_MUL  = 6'h03;
  localparam logic [5:0] OPRN_SRL  = 6'h04;
  localparam logic [5:0] OPRN_SLL  = 6'h05;
  localparam logic [5:0] OPRN_AND  = 6'h06;
  localparam logic [5:0] OPRN_OR   = 6'h07;
  localparam logic [5:0] OPRN_NOR  = 6'h08;
  localparam logic [5:0] OPRN_SLT  = 6'h09;

  // Width of the settle counter; covers a settle window of up to 15 cycles
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: maps opcode/funct to an ALU operation
// code and selects the two ALU operands. err flags unsupported instructions.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [4:0]            shamt,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic [15:0]           imm,
  output logic [OPRN_WIDTH-1:0] oprn,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic                  err
);

  logic signed [DATA_WIDTH-1:0] imm_sx;
  logic        [DATA_WIDTH-1:0] imm_zx;
  logic        [DATA_WIDTH-1:0] shamt_zx;
  logic        [5:0]            code;

  assign imm_sx   = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zx   = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_zx = {{(DATA_WIDTH-5){1'b0}}, shamt};

  // Operation and operand selection; anything unrecognised raises err
  always_comb begin
    code = OPRN_NONE;
    op1  = rs;
    op2  = rt;
    err  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: code = OPRN_ADD;
          FN_SUB: code = OPRN_SUB;
          FN_MUL: code = OPRN_MUL;
          FN_AND: code = OPRN_AND;
          FN_OR:  code = OPRN_OR;
          FN_NOR: code = OPRN_NOR;
          FN_SLT: code = OPRN_SLT;
          FN_SRL: begin
            code = OPRN_SRL;
            op2  = shamt_zx;
          end
          FN_SLL: begin
            code = OPRN_SLL;
            op2  = shamt_zx;
          end
          default: err = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        code = OPRN_ADD;
        op2  = imm_sx;
      end
      OPC_MULI: begin
        code = OPRN_MUL;
        op2  = imm_sx;
      end
      OPC_SLTI: begin
        code = OPRN_SLT;
        op2  = imm_sx;
      end
      OPC_ANDI: begin
        code = OPRN_AND;
        op2  = imm_zx;
      end
      OPC_ORI: begin
        code = OPRN_OR;
        op2  = imm_zx;
      end
      // Branch compare: subtract, the consumer looks at the zero flag
      OPC_BEQ, OPC_BNE: code = OPRN_SUB;
      default: err = 1'b1;
    endcase
  end

  assign oprn = OPRN_WIDTH'(code);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator for a combinational ALU: accepts a decoded
// instruction, drives registered ALU operands for a settle window,
// captures OUT/ZERO and returns them over a valid/ready response.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [5:0]            REQ_OPCODE,
  input  logic [5:0]            REQ_FUNCT,
  input  logic [4:0]            REQ_SHAMT,
  input  logic [DATA_WIDTH-1:0] REQ_RS,
  input  logic [DATA_WIDTH-1:0] REQ_RT,
  input  logic [15:0]           REQ_IMM,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RESULT,
  output logic                  RSP_ZERO,
  output logic                  RSP_ERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  logic                    accept;
  logic                    capture;
  logic                    rsp_done;
  logic                    req_ready_c;

  logic [OPRN_WIDTH-1:0]   dec_oprn;
  logic [DATA_WIDTH-1:0]   dec_op1;
  logic [DATA_WIDTH-1:0]   dec_op2;
  logic                    dec_err;

  logic [DATA_WIDTH-1:0]   alu_op1_q;
  logic [DATA_WIDTH-1:0]   alu_op2_q;
  logic [OPRN_WIDTH-1:0]   alu_oprn_q;
  logic [DATA_WIDTH-1:0]   rsp_result_q;
  logic                    rsp_zero_q;
  logic                    rsp_err_q;
  logic                    rsp_valid_q;

  alu_op_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .OPRN_WIDTH (OPRN_WIDTH)
  ) u_decode (
    .opcode (REQ_OPCODE),
    .funct  (REQ_FUNCT),
    .shamt  (REQ_SHAMT),
    .rs     (REQ_RS),
    .rt     (REQ_RT),
    .imm    (REQ_IMM),
    .oprn   (dec_oprn),
    .op1    (dec_op1),
    .op2    (dec_op2),
    .err    (dec_err)
  );

  // State register; reset returns to IDLE ahead of any other event
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (REQ_VALID) begin
          accept    = 1'b1;
          state_nxt = dec_err ? RESP : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && RSP_READY) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand issue, settle countdown, result capture and response release
  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt   <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_oprn_q   <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (dec_err) begin
          rsp_result_q <= '0;
          rsp_zero_q   <= 1'b0;
          rsp_err_q    <= 1'b1;
          rsp_valid_q  <= 1'b1;
        end else begin
          alu_op1_q  <= dec_op1;
          alu_op2_q  <= dec_op2;
          alu_oprn_q <= dec_oprn;
          settle_cnt <= CNT_LOAD;
        end
      end
      if (state == SETTLE) begin
        if (capture) begin
          rsp_result_q <= ALU_OUT;
          rsp_zero_q   <= ALU_ZERO;
          rsp_err_q    <= 1'b0;
          rsp_valid_q  <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt - 1'b1;
        end
      end
      if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign REQ_READY  = req_ready_c;
  assign ALU_OP1    = alu_op1_q;
  assign ALU_OP2    = alu_op2_q;
  assign ALU_OPRN   = alu_oprn_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_ZERO   = rsp_zero_q;
  assign RSP_ERR    = rsp_err_q;

endmodule
